// File: rtl/z23_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : z23_pkg                                                    |
// | Brief   : Shared widths and FSM state encoding for the z23 DMA.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package z23_pkg;

  localparam int DMA_ADDR_W = 16;
  localparam int DMA_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5
  } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/z23_dma_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : z23_dma_counter                                            |
// | Brief   : Loadable up/down counter with zero flag, used for the DMA  |
// |           source pointer, destination pointer and remaining count.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module z23_dma_counter
  import z23_pkg::*;
#(
  parameter int WIDTH = DMA_ADDR_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load has priority over counting; arithmetic wraps modulo 2^WIDTH.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/z23_dma.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : z23_dma                                                    |
// | Brief   : Single-channel byte-copy DMA initiator on the z23 bus.     |
// |           Copies 3 cycles/byte, releases the bus every               |
// |           BYTES_PER_GRANT bytes or when the grant is withdrawn.      |
// |           Optional macro Z23_DMA_FILL_EN adds a memset mode          |
// |           (ports fill_en / fill_value, 1 cycle/byte).                |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module z23_dma
  import z23_pkg::*;
#(
  parameter int BYTES_PER_GRANT = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [DMA_ADDR_W-1:0] src_addr,
  input  logic [DMA_ADDR_W-1:0] dst_addr,
  input  logic [DMA_ADDR_W-1:0] length,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic [DMA_ADDR_W-1:0] memory_address_out,
  input  logic [DMA_DATA_W-1:0] memory_data_in,
  output logic [DMA_DATA_W-1:0] memory_data_out,
  output logic                  memory_wr,
  output logic                  busy,
  output logic                  done
`ifdef Z23_DMA_FILL_EN
  ,
  input  logic                  fill_en,
  input  logic [DMA_DATA_W-1:0] fill_value
`endif
);

  localparam logic [DMA_ADDR_W-1:0] c_burst_load = DMA_ADDR_W'(BYTES_PER_GRANT);

  dma_state_t            state;
  dma_state_t            next_state;
  logic [DMA_ADDR_W-1:0] src_ptr;
  logic [DMA_ADDR_W-1:0] dst_ptr;
  logic [DMA_ADDR_W-1:0] remaining;
  logic [DMA_ADDR_W-1:0] burst_cnt;
  logic [DMA_DATA_W-1:0] data_reg;
  logic                  src_zero;
  logic                  dst_zero;
  logic                  rem_zero;
  logic                  drop_req;
  logic                  fill_mode;
  logic                  launch;
  logic                  step;
  logic                  last_byte;
  logic                  burst_last;
  logic                  unused_ptr_zero;

  // A real transfer starts only from IDLE with a non-zero length.
  assign launch     = (state == ST_IDLE) && start && (length != '0);
  assign step       = (state == ST_WR);
  // rem_zero is a safety net: a zero count in WR must still terminate.
  assign last_byte  = (remaining == DMA_ADDR_W'(1)) || rem_zero;
  assign burst_last = (burst_cnt == DMA_ADDR_W'(1));
  assign busy       = (state != ST_IDLE);
  assign unused_ptr_zero = src_zero ^ dst_zero;

  z23_dma_counter #(.WIDTH(DMA_ADDR_W)) u_src_ptr (
    .clk        (clk),
    .nrst       (nrst),
    .load       (launch),
    .load_value (src_addr),
    .en         (step),
    .up         (1'b1),
    .count      (src_ptr),
    .zero       (src_zero)
  );

  z23_dma_counter #(.WIDTH(DMA_ADDR_W)) u_dst_ptr (
    .clk        (clk),
    .nrst       (nrst),
    .load       (launch),
    .load_value (dst_addr),
    .en         (step),
    .up         (1'b1),
    .count      (dst_ptr),
    .zero       (dst_zero)
  );

  z23_dma_counter #(.WIDTH(DMA_ADDR_W)) u_remaining (
    .clk        (clk),
    .nrst       (nrst),
    .load       (launch),
    .load_value (length),
    .en         (step),
    .up         (1'b0),
    .count      (remaining),
    .zero       (rem_zero)
  );

`ifdef Z23_DMA_FILL_EN
  logic fill_q;

  // Transfer mode is frozen at launch.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fill_q <= 1'b0;
    end else if (launch) begin
      fill_q <= fill_en;
    end
  end

  assign fill_mode = fill_q;
`else
  assign fill_mode = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Marks the first REQ cycle after a bus release, during which bus_req is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      drop_req <= 1'b0;
    end else begin
      drop_req <= (state == ST_WR) && (next_state == ST_REQ);
    end
  end

  // Burst budget: reloaded on each grant, spent one per written byte.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      burst_cnt <= '0;
    end else if ((state == ST_REQ) && (next_state != ST_REQ)) begin
      burst_cnt <= c_burst_load;
    end else if (step) begin
      burst_cnt <= burst_cnt - DMA_ADDR_W'(1);
    end
  end

  // Data register: read data captured in CAP, or the fill pattern at launch.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_reg <= '0;
    end else if (state == ST_CAP) begin
      data_reg <= memory_data_in;
    end
`ifdef Z23_DMA_FILL_EN
    else if (launch && fill_en) begin
      data_reg <= fill_value;
    end
`endif
  end

  // Next-state and bus outputs, all decoded from the current state.
  always_comb begin
    next_state         = state;
    bus_req            = 1'b0;
    memory_address_out = '0;
    memory_data_out    = '0;
    memory_wr          = 1'b0;
    done               = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (length == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        bus_req = !drop_req;
        if (!drop_req && bus_gnt) begin
          next_state = fill_mode ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        bus_req            = 1'b1;
        memory_address_out = src_ptr;
        next_state         = ST_CAP;
      end
      ST_CAP: begin
        bus_req            = 1'b1;
        memory_address_out = src_ptr;
        next_state         = ST_WR;
      end
      ST_WR: begin
        bus_req            = 1'b1;
        memory_address_out = dst_ptr;
        memory_data_out    = data_reg;
        memory_wr          = 1'b1;
        if (last_byte) begin
          next_state = ST_DONE;
        end else if (burst_last || !bus_gnt) begin
          next_state = ST_REQ;
        end else begin
          next_state = fill_mode ? ST_WR : ST_RD;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/z23_dma.md
Z23_DMA -- requirements
Module: z23_dma

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  system clock, all state on rising edge; nrst  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: start  in  1  one-cycle pulse to launch a transfer; src_addr  in  16  first source byte address; dst_addr  in  16  first destination byte address; length  in  16  byte count.
REQ-003 SHALL have: bus_req  out  1  request ownership of the z23 memory bus; bus_gnt  in  1  ownership granted by the arbiter.
REQ-004 SHALL have: memory_address_out  out  16  bus address; memory_data_in  in  8  read data from memory; memory_data_out  out  8  write data; memory_wr  out  1  write strobe.
REQ-005 SHALL have: busy  out  1  transfer in progress; done  out  1  one-cycle completion pulse.
REQ-006 SHALL have parameter BYTES_PER_GRANT, default 16, meaning the number of bytes copied before bus_req is released and re-requested (burst limit, 1..65535).

Function
REQ-007 SHALL act as bus initiator toward a registered memory responder: memory_data_in is valid the cycle after the address is driven with memory_wr=0, and a write commits on the edge that samples memory_wr=1.
REQ-008 SHALL implement states IDLE, REQ, RD, CAP, WR, DONE.
REQ-009 IDLE: start=1 with length!=0 latches src_addr, dst_addr and length, then goes to REQ; start with length=0 goes to DONE with no bus activity.
REQ-010 REQ: bus_req=1; moves to RD on the edge where bus_gnt=1.
REQ-011 RD: drives memory_address_out=src pointer, memory_wr=0; goes to CAP.
REQ-012 CAP: captures memory_data_in into an 8-bit data register at cycle end; goes to WR.
REQ-013 WR: drives memory_address_out=dst pointer, memory_data_out=data register, memory_wr=1; increments both pointers, decrements the remaining count and the burst count.
REQ-014 After WR: remaining=0 goes to DONE; burst count exhausted or bus_gnt=0 goes to REQ with bus_req dropped for exactly one cycle; otherwise goes to RD.
REQ-015 Throughput SHALL be exactly 3 cycles per byte while the grant is held.
REQ-016 DONE: done=1 for one cycle, bus_req=0; goes to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 Pointers SHALL wrap 0xFFFF->0x0000 modulo 2^16 with no error.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 Outside RD/CAP/WR: memory_address_out=0, memory_data_out=0, memory_wr=0.
REQ-021 bus_gnt SHALL be sampled only in REQ and at the end of WR; a drop in RD or CAP is not observed until WR completes.

Reset
REQ-022 nrst low SHALL immediately force IDLE, pointers, counts and data register to 0, and all outputs to 0, including mid-transfer; a partial copy is left as is.

Configuration
REQ-023 With Z23_DMA_FILL_EN defined, a port fill_en (in, 1) and the value port fill_value (in, 8) SHALL exist; start with fill_en=1 skips RD/CAP, writes fill_value to length bytes from dst_addr at 1 cycle per byte, and never reads src_addr.
REQ-024 Without Z23_DMA_FILL_EN, those ports SHALL be absent and only copy is supported.

Structure
REQ-025 The state enum, DMA_ADDR_W=16 and DMA_DATA_W=8 SHALL live in shared package z23_pkg.
REQ-026 One sub-module, z23_dma_counter (loadable 16-bit up/down counter with zero flag), SHALL be instantiated for the src pointer, the dst pointer and the remaining count.

Verification
REQ-027 Copy: src=0x0010, dst=0xE000, len=4, gnt tied 1, ROM 0x10..0x13 = 11 22 33 44 -> RAM 0xE000..0xE003 = 11 22 33 44; done 13 cycles after the grant edge.
REQ-028 len=0: start -> done pulses on the next cycle; bus_req and memory_wr never assert.
REQ-029 Burst limit: BYTES_PER_GRANT=2, len=5 -> bus_req drops for one cycle after bytes 2 and 4; all 5 bytes are correct.
REQ-030 Wrap: dst=0xFFFF, len=2 -> writes land at 0xFFFF and then 0x0000.
REQ-031 Reset mid-transfer: nrst low during CAP of byte 3 of 8 -> all outputs 0 at once, busy=0, bytes 1-2 written, no further writes.
REQ-032 Fill (Z23_DMA_FILL_EN): dst=0xE100, len=3, fill_value=0xA5 -> 3 consecutive cycles with memory_wr=1 writing A5 A5 A5; no reads.
